// File: rtl/ahb3lite_pkg.sv
// Shared AHB-Lite encodings and slave FSM state type for the memory slave.
package ahb3lite_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } HTRANS_state;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'd0,
    HBURST_INCR   = 3'd1,
    HBURST_WRAP4  = 3'd2,
    HBURST_INCR4  = 3'd3,
    HBURST_WRAP8  = 3'd4,
    HBURST_INCR8  = 3'd5,
    HBURST_WRAP16 = 3'd6,
    HBURST_INCR16 = 3'd7
  } HBURST_Type;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } HRESP_state;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } slave_state_e;

  localparam int unsigned WAIT_CNT_W  = 4;
  localparam logic [7:0]  ERR_CNT_MAX = 8'hFF;

  function automatic int unsigned size_bytes(input logic [2:0] size);
    return 32'd1 << size;
  endfunction

endpackage

// File: rtl/ahb3lite_byte_lane.sv
// Byte-enable decode from transfer size and the low address bits.
module ahb3lite_byte_lane
  import ahb3lite_pkg::*;
#(
  parameter int unsigned BYTES  = 4,
  parameter int unsigned LANE_W = 2
) (
  input  logic [2:0]        size_i,
  input  logic [LANE_W-1:0] addr_lo_i,
  output logic [BYTES-1:0]  be_o
);

  int unsigned lo_u;
  int unsigned n_u;

  always_comb begin
    be_o = '0;
    lo_u = 32'(addr_lo_i);
    n_u  = size_bytes(size_i);
    for (int unsigned i = 0; i < BYTES; i++) begin
      if ((i >= lo_u) && (i < lo_u + n_u)) begin
        be_o[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ahb3lite_mem_slave.sv
// AHB-Lite slave bridging bus transfers onto a synchronous single-port memory,
// with programmable wait states and a two-cycle ERROR response.
module ahb3lite_mem_slave
  import ahb3lite_pkg::*;
#(
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       MEM_DEPTH = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned       WAIT_N    = 0
) (
  input  logic                         HCLK,
  input  logic                         HRESET,
  input  logic                         HSEL,
  input  logic [ADDR_W-1:0]            HADDR,
  input  logic [DATA_W-1:0]            HWDATA,
  input  logic                         HWRITE,
  input  logic [2:0]                   HSIZE,
  input  HBURST_Type                   HBURST,
  input  HTRANS_state                  HTRANS,
  input  logic                         HREADY,
  output logic                         HREADYOUT,
  output HRESP_state                   HRESP,
  output logic [DATA_W-1:0]            HRDATA,
  output logic [$clog2(MEM_DEPTH)-1:0] mem_addr,
  output logic                         mem_we,
  output logic                         mem_re,
  output logic [DATA_W/8-1:0]          mem_be,
  output logic [DATA_W-1:0]            mem_wdata,
  input  logic [DATA_W-1:0]            mem_rdata,
  output logic [7:0]                   err_cnt
);

  localparam int unsigned BYTES  = DATA_W / 8;
  localparam int unsigned LANE_W = $clog2(BYTES);
  localparam int unsigned MEM_AW = $clog2(MEM_DEPTH);
  localparam int unsigned AW1    = ADDR_W + 1;
  localparam logic [ADDR_W:0] SPAN = AW1'(MEM_DEPTH * BYTES);
  localparam logic [WAIT_CNT_W-1:0] WR_WAIT_LOAD = WAIT_CNT_W'(WAIT_N - 1);
  localparam logic [WAIT_CNT_W-1:0] RD_WAIT_LOAD =
    (WAIT_N == 0) ? '0 : WAIT_CNT_W'(WAIT_N - 1);

  slave_state_e            state_q, state_d;
  logic                    write_q, write_d;
  logic [2:0]              size_q, size_d;
  logic [ADDR_W-1:0]       off_q, off_d;
  logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
  logic                    rd_issue_q, rd_issue_d;
  logic                    rd_ret_q;
  logic [DATA_W-1:0]       rdata_q;
  logic [7:0]              err_cnt_q, err_cnt_d;

  logic                    accept;
  logic [ADDR_W-1:0]       addr_off;
  logic [ADDR_W-1:0]       align_mask;
  logic                    in_range, size_ok, aligned, req_ok;
  logic                    unused_bits;

  assign accept     = HSEL && HREADY &&
                      ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));
  assign addr_off   = HADDR - BASE_ADDR;
  assign in_range   = (HADDR >= BASE_ADDR) && ({1'b0, addr_off} < SPAN);
  assign size_ok    = HSIZE <= 3'(LANE_W);
  assign align_mask = (ADDR_W'(1) << HSIZE) - ADDR_W'(1);
  assign aligned    = (HADDR & align_mask) == '0;
  assign req_ok     = in_range && size_ok && aligned;

  always_comb begin
    state_d    = state_q;
    write_d    = write_q;
    size_d     = size_q;
    off_d      = off_q;
    cnt_d      = cnt_q;
    rd_issue_d = 1'b0;
    err_cnt_d  = err_cnt_q;
    case (state_q)
      ST_WAIT: begin
        if (cnt_q == '0) state_d = ST_DATA;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_ERR1: state_d = ST_ERR2;
      // IDLE, DATA and ERR2 all drive HREADYOUT=1, so each may take a new address phase
      default: begin
        state_d = ST_IDLE;
        if (accept) begin
          write_d = HWRITE;
          size_d  = HSIZE;
          off_d   = addr_off;
          if (!req_ok) begin
            state_d = ST_ERR1;
            if (err_cnt_q != ERR_CNT_MAX) err_cnt_d = err_cnt_q + 8'd1;
          end else if (HWRITE) begin
            if (WAIT_N == 0) begin
              state_d = ST_DATA;
            end else begin
              state_d = ST_WAIT;
              cnt_d   = WR_WAIT_LOAD;
            end
          end else begin
            state_d    = ST_WAIT;
            cnt_d      = RD_WAIT_LOAD;
            rd_issue_d = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q    <= ST_IDLE;
      write_q    <= 1'b0;
      size_q     <= '0;
      off_q      <= '0;
      cnt_q      <= '0;
      rd_issue_q <= 1'b0;
      rd_ret_q   <= 1'b0;
      rdata_q    <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      write_q    <= write_d;
      size_q     <= size_d;
      off_q      <= off_d;
      cnt_q      <= cnt_d;
      rd_issue_q <= rd_issue_d;
      rd_ret_q   <= rd_issue_q;
      // Memory data is only guaranteed the cycle after mem_re; hold it for longer waits
      if (rd_ret_q) rdata_q <= mem_rdata;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign HREADYOUT = (state_q != ST_WAIT) && (state_q != ST_ERR1);
  assign HRESP     = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  assign HRDATA    = ((state_q == ST_DATA) && !write_q) ? (rd_ret_q ? mem_rdata : rdata_q) : '0;
  assign mem_we    = (state_q == ST_DATA) && write_q;
  assign mem_re    = rd_issue_q;
  assign mem_addr  = off_q[LANE_W +: MEM_AW];
  assign mem_wdata = HWDATA;
  assign err_cnt   = err_cnt_q;

  ahb3lite_byte_lane #(
    .BYTES  (BYTES),
    .LANE_W (LANE_W)
  ) u_byte_lane (
    .size_i    (size_q),
    .addr_lo_i (off_q[LANE_W-1:0]),
    .be_o      (mem_be)
  );

  assign unused_bits = ^{HBURST, off_q};

endmodule

// File: tb/tb_ahb3lite_mem_slave.sv
// Randomized self-checking bench: two slaves (no wait / 3 wait states) against a byte-level reference model.
module tb_ahb3lite_mem_slave;
  import ahb3lite_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              mem_init;
  logic [1:0]        sel;
  logic [31:0]       haddr;
  logic [31:0]       hwdata;
  logic              hwrite;
  logic [2:0]        hsize;
  HBURST_Type        hburst;
  HTRANS_state       htrans;

  logic [1:0]        hro;
  logic [1:0]        hresp_b;
  logic [1:0][31:0]  hrdata;
  logic [1:0][9:0]   maddr;
  logic [1:0]        we;
  logic [1:0]        re;
  logic [1:0][3:0]   be;
  logic [1:0][31:0]  wd;
  logic [1:0][31:0]  mrd;
  logic [1:0][7:0]   ecnt;

  logic [31:0] mem  [2][1024];
  logic [7:0]  refm [2][4096];
  int          err_model [2];

  int n_checks = 0;
  int n_fail   = 0;

  int          obs_lows, obs_we, obs_re;
  logic [31:0] obs_rdata, obs_wdata;
  logic [3:0]  obs_be;
  logic [9:0]  obs_maddr;
  logic        obs_err_first, obs_err_done;

  always #5 clk = ~clk;

  ahb3lite_mem_slave #(
    .DATA_W(32), .ADDR_W(32), .MEM_DEPTH(1024), .BASE_ADDR(32'h0000_0000), .WAIT_N(0)
  ) u_dut0 (
    .HCLK(clk), .HRESET(rst), .HSEL(sel[0]), .HADDR(haddr), .HWDATA(hwdata),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HTRANS(htrans), .HREADY(hro[0]),
    .HREADYOUT(hro[0]), .HRESP(hresp_b[0]), .HRDATA(hrdata[0]),
    .mem_addr(maddr[0]), .mem_we(we[0]), .mem_re(re[0]), .mem_be(be[0]),
    .mem_wdata(wd[0]), .mem_rdata(mrd[0]), .err_cnt(ecnt[0])
  );

  ahb3lite_mem_slave #(
    .DATA_W(32), .ADDR_W(32), .MEM_DEPTH(1024), .BASE_ADDR(32'h0000_8000), .WAIT_N(3)
  ) u_dut1 (
    .HCLK(clk), .HRESET(rst), .HSEL(sel[1]), .HADDR(haddr), .HWDATA(hwdata),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HTRANS(htrans), .HREADY(hro[1]),
    .HREADYOUT(hro[1]), .HRESP(hresp_b[1]), .HRDATA(hrdata[1]),
    .mem_addr(maddr[1]), .mem_we(we[1]), .mem_re(re[1]), .mem_be(be[1]),
    .mem_wdata(wd[1]), .mem_rdata(mrd[1]), .err_cnt(ecnt[1])
  );

  function automatic logic [31:0] base_of(input int k);
    return (k == 1) ? 32'h0000_8000 : 32'h0000_0000;
  endfunction

  function automatic int waitn_of(input int k);
    return (k == 1) ? 3 : 0;
  endfunction

  function automatic logic [31:0] init_word(input int k, input int i);
    return (32'(i) * 32'h9E37_79B1) ^ ((k == 1) ? 32'h5A5A_1234 : 32'h1357_9BDF);
  endfunction

  // Memory behind each slave: byte-masked writes, registered reads
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (mem_init) begin
        for (int i = 0; i < 1024; i++) mem[k][i] <= init_word(k, i);
      end else if (we[k]) begin
        for (int b = 0; b < 4; b++)
          if (be[k][b]) mem[k][maddr[k]][8*b +: 8] <= wd[k][8*b +: 8];
      end
      if (re[k]) mrd[k] <= mem[k][maddr[k]];
    end
  end

  function automatic logic [31:0] ref_word(input int k, input int off);
    logic [31:0] w;
    int base_b;
    base_b = off - (off % 4);
    for (int l = 0; l < 4; l++) w[8*l +: 8] = refm[k][base_b + l];
    return w;
  endfunction

  task automatic ref_write(input int k, input int off, input int nbytes, input logic [31:0] data);
    for (int b = 0; b < nbytes; b++) refm[k][off + b] = data[8*((off + b) % 4) +: 8];
  endtask

  // Non-pipelined single transfer; records what the slave did during the data phase
  task automatic xfer(input int k, input logic wr, input logic [31:0] addr,
                      input logic [2:0] size, input logic [31:0] wdata);
    bit done;
    @(negedge clk);
    sel = 2'b00; sel[k] = 1'b1;
    haddr = addr; hwrite = wr; hsize = size;
    htrans = HTRANS_NONSEQ; hburst = HBURST_SINGLE; hwdata = $urandom;
    @(negedge clk);
    htrans = HTRANS_IDLE; hwdata = wdata;
    obs_lows = 0; obs_we = 0; obs_re = 0; obs_rdata = 'x;
    obs_be = '0; obs_maddr = '0; obs_wdata = '0;
    obs_err_first = 1'b0; obs_err_done = 1'b0;
    done = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (we[k]) begin obs_we++; obs_be = be[k]; obs_maddr = maddr[k]; obs_wdata = wd[k]; end
      if (re[k]) obs_re++;
      if (hro[k]) begin
        obs_rdata = hrdata[k]; obs_err_done = hresp_b[k]; done = 1;
        break;
      end
      if (obs_lows == 0) obs_err_first = hresp_b[k];
      obs_lows++;
      @(negedge clk);
    end
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL xfer_timeout dut=%0d addr=%h: HREADYOUT stayed low, required high within 40 cycles", k, addr);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_init = 1'b1; sel = '0; haddr = '0; hwdata = '0; hwrite = 1'b0;
    hsize = 3'd0; hburst = HBURST_SINGLE; htrans = HTRANS_IDLE;
    for (int k = 0; k < 2; k++) begin
      err_model[k] = 0;
      for (int i = 0; i < 1024; i++) ref_write(k, 4*i, 4, init_word(k, i));
    end
    repeat (3) @(negedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if ({hro[k], hresp_b[k], hrdata[k], we[k], re[k], ecnt[k]} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 8'h0}) begin
        n_fail++;
        $display("FAIL reset_state dut=%0d got ready=%b resp=%b rdata=%h we=%b re=%b err=%0d required 1 0 0 0 0 0",
                 k, hro[k], hresp_b[k], hrdata[k], we[k], re[k], ecnt[k]);
      end
    end
    // first edge after deassertion must already accept a transfer
    @(negedge clk);
    rst = 1'b0; mem_init = 1'b0;
    sel = 2'b01; haddr = 32'h40; hwrite = 1'b1; hsize = 3'd2; htrans = HTRANS_NONSEQ;
    @(negedge clk);
    htrans = HTRANS_IDLE; hwdata = 32'hCAFE_0040;
    #1;
    n_checks++;
    if ({we[0], maddr[0]} !== {1'b1, 10'd16}) begin
      n_fail++;
      $display("FAIL reset_first_accept got we=%b addr=%0d required we=1 addr=16", we[0], maddr[0]);
    end
    ref_write(0, 32'h40, 4, 32'hCAFE_0040);
  endtask

  task automatic test_single_write();
    xfer(0, 1'b1, 32'h10, 3'd2, 32'hDEAD_BEEF);
    n_checks++;
    if ({obs_lows, obs_we, obs_maddr, obs_be, obs_wdata} !== {32'd0, 32'd1, 10'd4, 4'b1111, 32'hDEAD_BEEF}) begin
      n_fail++;
      $display("FAIL single_write got lows=%0d we=%0d addr=%0d be=%b wdata=%h required 0 1 4 1111 deadbeef",
               obs_lows, obs_we, obs_maddr, obs_be, obs_wdata);
    end
    ref_write(0, 32'h10, 4, 32'hDEAD_BEEF);
  endtask

  task automatic test_byte_write();
    xfer(0, 1'b1, 32'h13, 3'd0, 32'h1122_3344);
    n_checks++;
    if ({obs_we, obs_maddr, obs_be} !== {32'd1, 10'd4, 4'b1000}) begin
      n_fail++;
      $display("FAIL byte_write got we=%0d addr=%0d be=%b required 1 4 1000", obs_we, obs_maddr, obs_be);
    end
    ref_write(0, 32'h13, 1, 32'h1122_3344);
    xfer(0, 1'b0, 32'h10, 3'd2, 32'h0);
    n_checks++;
    if ({obs_lows, obs_re, obs_we, obs_rdata} !== {32'd1, 32'd1, 32'd0, 32'h11AD_BEEF}) begin
      n_fail++;
      $display("FAIL byte_readback got lows=%0d re=%0d we=%0d rdata=%h required 1 1 0 11adbeef",
               obs_lows, obs_re, obs_we, obs_rdata);
    end
  endtask

  task automatic test_read_wait();
    logic [31:0] exp_w;
    exp_w = ref_word(1, 32'h20);
    xfer(1, 1'b0, 32'h0000_8020, 3'd2, 32'h0);
    n_checks++;
    if ({obs_lows, obs_re, obs_we, obs_rdata, obs_err_done} !== {32'd3, 32'd1, 32'd0, exp_w, 1'b0}) begin
      n_fail++;
      $display("FAIL read_wait3 got lows=%0d re=%0d we=%0d rdata=%h resp=%b required 3 1 0 %h 0",
               obs_lows, obs_re, obs_we, obs_rdata, obs_err_done, exp_w);
    end
  endtask

  task automatic test_error();
    xfer(0, 1'b1, 32'h1000, 3'd2, 32'h5555_AAAA);
    err_model[0]++;
    #1;
    n_checks++;
    if ({obs_lows, obs_err_first, obs_err_done, obs_we, obs_re, ecnt[0]} !==
        {32'd1, 1'b1, 1'b1, 32'd0, 32'd0, 8'(err_model[0])}) begin
      n_fail++;
      $display("FAIL error_resp got lows=%0d err1=%b err2=%b we=%0d re=%0d cnt=%0d required 1 1 1 0 0 %0d",
               obs_lows, obs_err_first, obs_err_done, obs_we, obs_re, ecnt[0], err_model[0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] bd [4];
    for (int b = 0; b < 4; b++) bd[b] = $urandom;
    @(negedge clk);
    sel = 2'b01; hwrite = 1'b1; hsize = 3'd2; hburst = HBURST_INCR4;
    htrans = HTRANS_NONSEQ; haddr = 32'h0;
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      if (b < 3) begin htrans = HTRANS_SEQ; haddr = 32'(4 * (b + 1)); end
      else htrans = HTRANS_IDLE;
      hwdata = bd[b];
      #1;
      n_checks++;
      if ({we[0], maddr[0], hro[0], wd[0]} !== {1'b1, 10'(b), 1'b1, bd[b]}) begin
        n_fail++;
        $display("FAIL burst_beat%0d got we=%b addr=%0d ready=%b wdata=%h required 1 %0d 1 %h",
                 b, we[0], maddr[0], hro[0], wd[0], b, bd[b]);
      end
      ref_write(0, 4 * b, 4, bd[b]);
    end
    hburst = HBURST_SINGLE;
  endtask

  task automatic test_idle_selected();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      sel = 2'b11;
      htrans = (c % 2 == 0) ? HTRANS_BUSY : HTRANS_IDLE;
      hwrite = 1'b1; haddr = base_of(c % 2);
      #1;
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if ({hro[k], we[k], re[k], hresp_b[k]} !== 4'b1000) begin
          n_fail++;
          $display("FAIL idle_selected dut=%0d got ready=%b we=%b re=%b resp=%b required 1 0 0 0",
                   k, hro[k], we[k], re[k], hresp_b[k]);
        end
      end
    end
    @(negedge clk);
    sel = 2'b00;
  endtask

  task automatic test_reset_wait();
    int wcount;
    logic [31:0] exp_w;
    @(negedge clk);
    sel = 2'b10; haddr = 32'h0000_8100; hwrite = 1'b1; hsize = 3'd2;
    htrans = HTRANS_NONSEQ; hwdata = 32'h0BAD_F00D;
    @(negedge clk);
    htrans = HTRANS_IDLE;
    #1;
    n_checks++;
    if (hro[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_wait_pre got ready=%b required 0", hro[1]);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({hro[1], we[1], ecnt[0], ecnt[1]} !== {1'b1, 1'b0, 8'h0, 8'h0}) begin
      n_fail++;
      $display("FAIL reset_wait_async got ready=%b we=%b cnt0=%0d cnt1=%0d required 1 0 0 0",
               hro[1], we[1], ecnt[0], ecnt[1]);
    end
    err_model[0] = 0; err_model[1] = 0;
    @(negedge clk);
    rst = 1'b0;
    wcount = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); #1;
      if (we[1]) wcount++;
    end
    n_checks++;
    if (wcount !== 0) begin
      n_fail++;
      $display("FAIL reset_wait_nowrite got writes=%0d required 0", wcount);
    end
    exp_w = ref_word(1, 32'h100);
    xfer(1, 1'b0, 32'h0000_8100, 3'd2, 32'h0);
    n_checks++;
    if (obs_rdata !== exp_w) begin
      n_fail++;
      $display("FAIL reset_wait_mem got rdata=%h required %h", obs_rdata, exp_w);
    end
  endtask

  task automatic test_random(input int k, input int n);
    logic [31:0] base, addr, off, wdata, exp_rdata;
    logic [2:0]  size;
    logic [3:0]  exp_be;
    logic        wr, valid;
    int r, nbytes, exp_lows, w;
    base = base_of(k); w = waitn_of(k);
    for (int t = 0; t < n; t++) begin
      r = $urandom_range(0, 99);
      size = (r < 5) ? 3'd3 : 3'($urandom_range(0, 2));
      wr = 1'($urandom_range(0, 1));
      wdata = $urandom;
      off = 32'($urandom_range(0, 4095));
      if ($urandom_range(0, 9) != 0) off = off & ~((32'd1 << size) - 32'd1);
      if (r >= 85) begin
        if (k == 1 && r >= 93) addr = base - 32'($urandom_range(1, 256));
        else addr = base + 32'h1000 + 32'($urandom_range(0, 1023));
      end else addr = base + off;

      nbytes = 1 << size;
      off = addr - base;
      valid = (addr >= base) && (off < 32'd4096) && (size <= 3'd2) && ((addr % nbytes) == 0);
      exp_lows = !valid ? 1 : (wr ? w : ((w > 0) ? w : 1));
      exp_be = '0;
      exp_rdata = '0;
      if (valid && wr)
        for (int b = 0; b < nbytes; b++) exp_be[(off % 4) + b] = 1'b1;
      if (valid && !wr) exp_rdata = ref_word(k, int'(off));

      xfer(k, wr, addr, size, wdata);
      if (!valid) err_model[k] = (err_model[k] < 255) ? err_model[k] + 1 : 255;
      if (valid && wr) ref_write(k, int'(off), nbytes, wdata);

      n_checks++;
      if ({obs_lows, obs_we, obs_re} !== {exp_lows, 32'(valid && wr), 32'(valid && !wr)}) begin
        n_fail++;
        $display("FAIL rand_timing dut=%0d addr=%h wr=%b size=%0d got lows=%0d we=%0d re=%0d required %0d %0d %0d",
                 k, addr, wr, size, obs_lows, obs_we, obs_re, exp_lows, valid && wr, valid && !wr);
      end
      n_checks++;
      if ({obs_err_first, obs_err_done} !== {!valid, !valid}) begin
        n_fail++;
        $display("FAIL rand_resp dut=%0d addr=%h got resp=%b%b required %b%b",
                 k, addr, obs_err_first, obs_err_done, !valid, !valid);
      end
      n_checks++;
      if (obs_rdata !== exp_rdata) begin
        n_fail++;
        $display("FAIL rand_rdata dut=%0d addr=%h got %h required %h", k, addr, obs_rdata, exp_rdata);
      end
      if (valid && wr) begin
        n_checks++;
        if ({obs_be, obs_maddr, obs_wdata} !== {exp_be, 10'(off >> 2), wdata}) begin
          n_fail++;
          $display("FAIL rand_write dut=%0d addr=%h got be=%b addr=%0d wdata=%h required %b %0d %h",
                   k, addr, obs_be, obs_maddr, obs_wdata, exp_be, off >> 2, wdata);
        end
      end
      #1;
      n_checks++;
      if (ecnt[k] !== 8'(err_model[k])) begin
        n_fail++;
        $display("FAIL rand_errcnt dut=%0d got %0d required %0d", k, ecnt[k], err_model[k]);
      end
    end
  endtask

  task automatic test_err_saturate();
    for (int i = 0; i < 260; i++) begin
      xfer(0, 1'b0, 32'h0000_2000, 3'd2, 32'h0);
      err_model[0] = (err_model[0] < 255) ? err_model[0] + 1 : 255;
    end
    #1;
    n_checks++;
    if (ecnt[0] !== 8'(err_model[0])) begin
      n_fail++;
      $display("FAIL err_saturate got %0d required %0d", ecnt[0], err_model[0]);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_byte_write();
    test_read_wait();
    test_error();
    test_back_to_back();
    test_idle_selected();
    test_random(0, 80);
    test_random(1, 60);
    test_reset_wait();
    test_random(1, 20);
    test_err_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
